// File: rtl/osd_spi_tx_pkg.sv
// Shared OSD command constants, FSM state type and command-byte helper.
// The OSD receiver side uses the same constants.
package osd_spi_tx_pkg;

    localparam logic [7:0] OSD_CMD_WRITE  = 8'h20;
    localparam logic [7:0] OSD_CMD_ENABLE = 8'h40;
    localparam int         OSD_LINES      = 8;
    localparam int         OSD_LINE_BYTES = 256;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL,
        ST_SHIFT,
        ST_FETCH,
        ST_FLUSH,
        ST_TAIL,
        ST_GAP
    } state_t;

    function automatic logic [7:0] osd_cmd_byte(input logic wr, input logic en,
                                                input logic [2:0] line);
        return wr ? (OSD_CMD_WRITE | {5'b00000, line}) : (OSD_CMD_ENABLE | {7'b0000000, en});
    endfunction

endpackage

// File: rtl/osd_spi_bitcell.sv
// SPI bit-cell engine: CLK_DIV-cycle low/high phases, MSB-first 8-bit shifter.
// o_byte_done fires on the cycle whose clock edge ends the last high phase.
module osd_spi_bitcell #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       i_load,
    input  logic       i_start,
    input  logic       i_single,
    input  logic [7:0] i_byte,
    output logic       o_sck,
    output logic       o_di,
    output logic       o_byte_done
);

    localparam int            CW      = $clog2(CLK_DIV) + 1;
    localparam logic [CW-1:0] PH_LAST = CW'(CLK_DIV - 1);

    logic          r_active;
    logic          r_high;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_sr;
    logic          r_sck;
    logic          w_ph_end;

    assign w_ph_end    = r_active && (r_cnt == PH_LAST);
    assign o_byte_done = w_ph_end && r_high && (r_bit == 3'd7);
    assign o_sck       = r_sck;
    assign o_di        = r_sr[7];

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_active <= 1'b0;
            r_high   <= 1'b0;
            r_cnt    <= '0;
            r_bit    <= 3'd0;
            r_sr     <= 8'h00;
            r_sck    <= 1'b0;
        end else if (i_load) begin
            // A single-bit cell (flush) starts at the last bit position
            r_sr     <= i_byte;
            r_bit    <= i_single ? 3'd7 : 3'd0;
            r_active <= i_start;
            r_high   <= 1'b0;
            r_cnt    <= '0;
            r_sck    <= 1'b0;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_high   <= 1'b0;
            r_cnt    <= '0;
            r_sck    <= 1'b0;
        end else if (r_active) begin
            if (!w_ph_end) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
                if (!r_high) begin
                    r_high <= 1'b1;
                    r_sck  <= 1'b1;
                end else begin
                    r_high <= 1'b0;
                    r_sck  <= 1'b0;
                    if (r_bit == 3'd7) begin
                        r_active <= 1'b0;
                    end else begin
                        r_bit <= r_bit + 3'd1;
                        r_sr  <= {r_sr[6:0], 1'b0};
                    end
                end
            end
        end
    end

endmodule

// File: rtl/osd_spi_tx.sv
// OSD command-port SPI master: sends the command byte, optional line payload,
// a flush cell, then holds SS3 high for a CS_GAP guard period.
module osd_spi_tx
    import osd_spi_tx_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 8
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic       cmd_enable,
    input  logic [2:0] cmd_line,
    input  logic [7:0] cmd_len_m1,
    input  logic       data_valid,
    output logic       data_ready,
    input  logic [7:0] data,
    output logic       busy,
    output logic       done,
    output logic       SPI_SCK,
    output logic       SPI_SS3,
    output logic       SPI_DI,
    output state_t     o_dbg_state
);

    localparam int            WMAX     = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int            WW       = $clog2(WMAX) + 1;
    localparam logic [WW-1:0] CD_LAST  = WW'(CLK_DIV - 1);
    localparam logic [WW-1:0] GAP_LAST = WW'(CS_GAP - 1);

    state_t        r_state;
    state_t        w_next;
    logic [WW-1:0] r_wait;
    logic [7:0]    r_bytes;
    logic          r_is_write;
    logic          r_in_data;
    logic          r_ss3;
    logic          r_busy;
    logic          r_done;

    logic          w_load;
    logic          w_start;
    logic          w_single;
    logic [7:0]    w_byte;
    logic          w_byte_done;

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // ready is a pure state decode and never depends on valid.
    assign cmd_ready   = (r_state == ST_IDLE);
    assign data_ready  = (r_state == ST_FETCH);
    assign busy        = r_busy;
    assign done        = r_done;
    assign SPI_SS3     = r_ss3;
    assign o_dbg_state = r_state;

    osd_spi_bitcell #(.CLK_DIV(CLK_DIV)) u_bitcell (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .i_load      (w_load),
        .i_start     (w_start),
        .i_single    (w_single),
        .i_byte      (w_byte),
        .o_sck       (SPI_SCK),
        .o_di        (SPI_DI),
        .o_byte_done (w_byte_done)
    );

    always_comb begin
        w_next   = r_state;
        w_load   = 1'b0;
        w_start  = 1'b0;
        w_single = 1'b0;
        w_byte   = osd_cmd_byte(cmd_write, cmd_enable, cmd_line);
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_load = 1'b1;
                    w_next = ST_SEL;
                end
            end
            ST_SEL: begin
                if (r_wait == CD_LAST) begin
                    w_start = 1'b1;
                    w_next  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_byte_done) begin
                    if (!r_is_write) begin
                        w_next = ST_TAIL;
                    end else if (r_in_data && (r_bytes == 8'd0)) begin
                        // Extra zero cell lets the receiver commit the last byte
                        w_load   = 1'b1;
                        w_start  = 1'b1;
                        w_single = 1'b1;
                        w_byte   = 8'h00;
                        w_next   = ST_FLUSH;
                    end else begin
                        w_next = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                if (data_valid) begin
                    w_load  = 1'b1;
                    w_start = 1'b1;
                    w_byte  = data;
                    w_next  = ST_SHIFT;
                end
            end
            ST_FLUSH: begin
                if (w_byte_done) w_next = ST_TAIL;
            end
            ST_TAIL: begin
                if (r_wait == CD_LAST) w_next = ST_GAP;
            end
            ST_GAP: begin
                if (r_wait == GAP_LAST) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_wait     <= '0;
            r_bytes    <= 8'd0;
            r_is_write <= 1'b0;
            r_in_data  <= 1'b0;
            r_ss3      <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= 1'b0;
            r_wait  <= (w_next != r_state) ? '0 : r_wait + 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_bytes    <= cmd_len_m1;
                        r_is_write <= cmd_write;
                        r_in_data  <= 1'b0;
                        r_ss3      <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (w_byte_done && r_in_data) r_bytes <= r_bytes - 8'd1;
                end
                ST_FETCH: begin
                    if (data_valid) r_in_data <= 1'b1;
                end
                ST_TAIL: begin
                    if (w_next == ST_GAP) begin
                        r_ss3  <= 1'b1;
                        r_done <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (w_next == ST_IDLE) r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_osd_spi_tx.sv
// Bench for osd_spi_tx: a behavioural OSD receiver captures the SPI stream into
// a line buffer, compared against an expected buffer built from the stimulus.
module tb_osd_spi_tx;
  import osd_spi_tx_pkg::*;

  localparam int CD    = 2;
  localparam int GAP   = 8;
  localparam int BUF_N = OSD_LINES * OSD_LINE_BYTES;
  localparam int TXN_LIMIT = 12000;

  // clock / reset
  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  always #5 clk_sys = ~clk_sys;

  logic       cmd_valid = 1'b0;
  logic       cmd_write = 1'b0;
  logic       cmd_enable = 1'b0;
  logic [2:0] cmd_line = 3'd0;
  logic [7:0] cmd_len_m1 = 8'd0;
  logic       data_valid = 1'b0;
  logic [7:0] data = 8'h00;
  logic       cmd_ready, data_ready, busy, done;
  logic       SPI_SCK, SPI_SS3, SPI_DI;
  state_t     dbg_state;

  osd_spi_tx #(.CLK_DIV(CD), .CS_GAP(GAP)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_enable  (cmd_enable),
    .cmd_line    (cmd_line),
    .cmd_len_m1  (cmd_len_m1),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .data        (data),
    .busy        (busy),
    .done        (done),
    .SPI_SCK     (SPI_SCK),
    .SPI_SS3     (SPI_SS3),
    .SPI_DI      (SPI_DI),
    .o_dbg_state (dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit         wr;
    bit         en;
    logic [2:0] line;
    int         len_m1;
    int         dpat;
    int         stall_after;
    int         stall_len;
    int         abort_rise;
    bit         clr_line;
    logic [7:0] exp_cmd;
    int         exp_rises;
    int         exp_ss3_low;
  } vec_t;

  // receiver model and protocol monitor state
  logic [7:0] rx_buf [0:BUF_N-1];
  logic [7:0] exp_buf [0:BUF_N-1];
  int         rises, ss3_low, done_cnt, fetch_viol, di_viol, ready_viol;
  int         run_high, min_gap;
  bit         seen_low;
  logic       prev_sck = 1'b0, prev_di = 1'b0, prev_ss3 = 1'b1;
  int         rx_bits;
  logic [7:0] rx_sr, rx_cmd, rx_pbyte, rx_idx;
  logic [2:0] rx_line;
  bit         rx_first, rx_wr, rx_pend;
  bit         osd_enable;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk_sys) begin
    logic [7:0] sr_n;
    if (SPI_SS3 === 1'b0) ss3_low++;
    if (done === 1'b1) done_cnt++;
    if (busy === 1'b1 && cmd_ready === 1'b1) ready_viol++;
    if (data_ready === 1'b1 && SPI_SCK === 1'b1) fetch_viol++;
    if (prev_sck === 1'b1 && SPI_SCK === 1'b1 && SPI_SS3 === 1'b0 && SPI_DI !== prev_di) di_viol++;
    if (SPI_SS3 === 1'b1) begin
      run_high++;
    end else if (SPI_SS3 === 1'b0) begin
      if (prev_ss3 === 1'b1 && seen_low && run_high < min_gap) min_gap = run_high;
      seen_low = 1'b1;
      run_high = 0;
    end
    // receiver: a completed payload byte is committed on the next SCK rise
    if (SPI_SS3 === 1'b1) begin
      rx_bits  = 0;
      rx_pend  = 1'b0;
      rx_first = 1'b0;
    end else if (prev_sck === 1'b0 && SPI_SCK === 1'b1) begin
      rises++;
      if (rx_pend) begin
        rx_buf[{rx_line, rx_idx}] = rx_pbyte;
        rx_idx  = rx_idx + 8'd1;
        rx_pend = 1'b0;
      end
      sr_n  = {rx_sr[6:0], SPI_DI};
      rx_sr = sr_n;
      rx_bits++;
      if (rx_bits == 8) begin
        rx_bits = 0;
        if (!rx_first) begin
          rx_first = 1'b1;
          rx_cmd   = sr_n;
          rx_wr    = 1'b0;
          if ((sr_n & 8'hF8) == OSD_CMD_WRITE) begin
            rx_wr   = 1'b1;
            rx_line = sr_n[2:0];
            rx_idx  = 8'd0;
          end else if ((sr_n & 8'hFE) == OSD_CMD_ENABLE) begin
            osd_enable = sr_n[0];
          end
        end else if (rx_wr) begin
          rx_pend  = 1'b1;
          rx_pbyte = sr_n;
        end
      end
    end
    prev_sck = SPI_SCK;
    prev_di  = SPI_DI;
    prev_ss3 = SPI_SS3;
  end

  function automatic vec_t mk(input bit wr, input bit en, input int line, input int len_m1,
                              input int dpat, input int st_after, input int st_len,
                              input int abort_rise, input bit clr);
    vec_t v;
    v.wr = wr; v.en = en; v.line = line[2:0]; v.len_m1 = len_m1; v.dpat = dpat;
    v.stall_after = st_after; v.stall_len = st_len; v.abort_rise = abort_rise; v.clr_line = clr;
    v.exp_cmd     = wr ? (8'h20 + 8'(line)) : (8'h40 + 8'(en));
    v.exp_rises   = wr ? (8 + 8 * (len_m1 + 1) + 1) : 8;
    v.exp_ss3_low = 18 * CD;
    return v;
  endfunction

  function automatic int buf_mismatches();
    int n = 0;
    for (int i = 0; i < BUF_N; i++) if (rx_buf[i] !== exp_buf[i]) n++;
    return n;
  endfunction

  task automatic tick();
    @(negedge clk_sys);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [7:0] dq[$];
    int k, cyc, stall_left, ncommit;
    bit fin;
    for (int i = 0; i <= v.len_m1; i++) begin
      if (v.dpat == 0)      dq.push_back(8'(i));
      else if (v.dpat == 1) dq.push_back(8'hA5);
      else                  dq.push_back(8'($urandom_range(0, 255)));
    end
    cyc = 0;
    while (cmd_ready !== 1'b1 && cyc < 200) begin tick(); cyc++; end
    check({tag, "_idle_wait"}, cmd_ready, 1);
    if (v.clr_line) begin
      for (int i = 0; i < OSD_LINE_BYTES; i++) begin
        rx_buf[{v.line, 8'(i)}]  = 8'h00;
        exp_buf[{v.line, 8'(i)}] = 8'h00;
      end
    end
    rises = 0; ss3_low = 0; done_cnt = 0; rx_cmd = 8'h00;
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_enable = v.en;
    cmd_line = v.line; cmd_len_m1 = 8'(v.len_m1);
    tick();
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom_range(0, 1)); cmd_line = 3'($urandom_range(0, 7));
    k = 0; stall_left = 0; cyc = 0; fin = 1'b0;
    while (!fin && cyc < TXN_LIMIT) begin
      if (v.abort_rise > 0 && rises >= v.abort_rise) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check({tag, "_rst_ss3"}, SPI_SS3, 1);
        check({tag, "_rst_sck"}, SPI_SCK, 0);
        check({tag, "_rst_di"}, SPI_DI, 0);
        check({tag, "_rst_busy"}, busy, 0);
        fin = 1'b1;
      end else begin
        if (stall_left > 0) begin
          data_valid = 1'b0;
          stall_left--;
        end else if (k < dq.size()) begin
          data_valid = 1'b1;
          data = dq[k];
        end else begin
          data_valid = 1'b0;
        end
        if (data_valid && data_ready === 1'b1) begin
          k++;
          if (v.stall_len > 0 && k == v.stall_after + 1) stall_left = v.stall_len;
        end
        tick();
        cyc++;
        if (cmd_ready === 1'b1) fin = 1'b1;
      end
    end
    data_valid = 1'b0;
    check({tag, "_finished"}, fin, 1);
    check({tag, "_cmd_byte"}, rx_cmd, v.exp_cmd);
    if (v.abort_rise > 0) begin
      ncommit = (v.abort_rise >= 17) ? (v.abort_rise - 17) / 8 + 1 : 0;
      if (ncommit > v.len_m1 + 1) ncommit = v.len_m1 + 1;
    end else begin
      ncommit = v.wr ? v.len_m1 + 1 : 0;
      check({tag, "_sck_rises"}, rises, v.exp_rises);
      check({tag, "_done_pulses"}, done_cnt, 1);
      if (!v.wr) begin
        check({tag, "_ss3_low"}, ss3_low, v.exp_ss3_low);
        check({tag, "_osd_enable"}, osd_enable, v.en);
      end
    end
    for (int i = 0; i < ncommit; i++) exp_buf[{v.line, 8'(i)}] = dq[i];
    check({tag, "_buffer"}, buf_mismatches(), 0);
  endtask

  initial begin
    vec_t tbl[6];
    vec_t rv;
    int   cyc;
    for (int i = 0; i < BUF_N; i++) begin rx_buf[i] = 8'h00; exp_buf[i] = 8'h00; end
    rises = 0; ss3_low = 0; done_cnt = 0; fetch_viol = 0; di_viol = 0; ready_viol = 0;
    run_high = 0; min_gap = 1000000; seen_low = 1'b0; rx_bits = 0; rx_sr = 8'h00;
    rx_cmd = 8'h00; rx_pbyte = 8'h00; rx_idx = 8'h00; rx_line = 3'd0;
    rx_first = 1'b0; rx_wr = 1'b0; rx_pend = 1'b0; osd_enable = 1'b0;

    //          wr en line len  dpat st_aft st_len abort clr
    tbl[0] = mk(0, 1, 0,   0,   0,   0,     0,     0,    0);
    tbl[1] = mk(1, 0, 5,   255, 0,   0,     0,     0,    0);
    tbl[2] = mk(1, 0, 5,   255, 0,   100,   50,    0,    1);
    tbl[3] = mk(1, 0, 7,   0,   1,   0,     0,     0,    0);
    tbl[4] = mk(1, 0, 3,   20,  2,   0,     0,     92,   0);
    tbl[5] = mk(0, 0, 0,   0,   0,   0,     0,     0,    0);

    repeat (3) @(negedge clk_sys);
    #1 reset = 1'b0;
    check("reset_ss3", SPI_SS3, 1);
    check("reset_sck", SPI_SCK, 0);
    check("reset_di", SPI_DI, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_cmd_ready", cmd_ready, 1);
    check("reset_data_ready", data_ready, 0);

    for (int i = 0; i < 6; i++) begin
      run_vec(tbl[i], $sformatf("tbl%0d", i));
      if (i == 2) check("stall_sck_static", fetch_viol, 0);
    end

    for (int i = 0; i < 6; i++) begin
      rv = mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 7),
              $urandom_range(0, 47), 2, 0, $urandom_range(0, 1) * $urandom_range(1, 6), 0, 0);
      rv.stall_after = $urandom_range(0, rv.len_m1);
      run_vec(rv, $sformatf("rnd%0d", i));
    end

    // back-to-back enables with cmd_valid held high
    tick();
    rises = 0; done_cnt = 0; rx_cmd = 8'h00; seen_low = 1'b0; min_gap = 1000000;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_enable = 1'b1;
    cyc = 0;
    while (done_cnt < 2 && cyc < 2000) begin tick(); cyc++; end
    cmd_valid = 1'b0;
    cyc = 0;
    while (cmd_ready !== 1'b1 && cyc < 200) begin tick(); cyc++; end
    check("b2b_done_pulses", done_cnt, 2);
    check("b2b_sck_rises", rises, 16);
    check("b2b_gap_ge_cs_gap", (min_gap >= GAP && min_gap < 1000), 1);
    check("b2b_osd_enable", osd_enable, 1);

    check("cmd_ready_while_busy", ready_viol, 0);
    check("sck_in_fetch", fetch_viol, 0);
    check("di_change_sck_high", di_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
